// File: rtl/cosim_ctrl_pkg.sv
// Shared types and defaults for the emulation run controller and its trace windows.
package cosim_ctrl_pkg;

  localparam int CNT_W_DEF = 64;
  localparam int WIN_CFG_W = CNT_W_DEF;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RUN,
    DONE,
    TOUT
  } run_state_e;

  // One trace window at the default counter width; win_end of 0 means never close.
  typedef struct packed {
    logic [WIN_CFG_W-1:0] win_start;
    logic [WIN_CFG_W-1:0] win_end;
  } win_cfg_t;

endpackage

// File: rtl/cosim_window.sv
// One trace-capture window: open from win_start up to (not including) win_end while running.
module cosim_window
  import cosim_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             run,
  input  logic [CNT_W-1:0] cycle,
  input  logic [CNT_W-1:0] win_start,
  input  logic [CNT_W-1:0] win_end,
  output logic             active,
  output logic             open
);

  // An end at or before the start (other than 0) can never satisfy both bounds.
  assign active = run && (cycle >= win_start) && ((win_end == '0) || (cycle < win_end));
  assign open   = active && (cycle == win_start);

endmodule

// File: rtl/cosim_run_ctrl.sv
// Run controller: sequences DUT reset, counts RUN cycles, drives trace windows, ends on done/timeout.
module cosim_run_ctrl
  import cosim_ctrl_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int NUM_WIN  = 2,
  parameter int RST_HOLD = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_WIN-1:0][CNT_W-1:0]   cfg_win_start,
  input  logic [NUM_WIN-1:0][CNT_W-1:0]   cfg_win_end,
  input  logic [CNT_W-1:0]                cfg_timeout,
  input  logic                            dut_done,
  output logic                            dut_reset,
  output logic [CNT_W-1:0]                cycle,
  output logic [NUM_WIN-1:0]              win_active,
  output logic [NUM_WIN-1:0]              win_open,
  output logic                            finished,
  output logic                            timed_out,
  output logic                            busy
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  run_state_e                    state, next_state;
  logic [HOLD_W-1:0]             hold_cnt;
  logic [NUM_WIN-1:0][CNT_W-1:0] win_start_q, win_end_q;
  logic [CNT_W-1:0]              timeout_q;
  logic                          timeout_hit;

  assign timeout_hit = (timeout_q != '0) && (cycle == timeout_q - CNT_W'(1));

  always_comb begin
    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = HOLD;
      HOLD:    if (hold_cnt == '0) next_state = RUN;
      RUN: begin
        if (dut_done)         next_state = DONE;
        else if (timeout_hit) next_state = TOUT;
      end
      default: next_state = state;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      dut_reset   <= 1'b1;
      busy        <= 1'b0;
      cycle       <= '0;
      finished    <= 1'b0;
      timed_out   <= 1'b0;
      hold_cnt    <= '0;
      // NOTE: config is a handful of flops, not a RAM, so it is reset like any other state.
      win_start_q <= '0;
      win_end_q   <= '0;
      timeout_q   <= '0;
    end else begin
      state     <= next_state;
      dut_reset <= (next_state == IDLE) || (next_state == HOLD);
      busy      <= (next_state == HOLD) || (next_state == RUN);

      if (state == IDLE && start) begin
        win_start_q <= cfg_win_start;
        win_end_q   <= cfg_win_end;
        timeout_q   <= cfg_timeout;
        hold_cnt    <= HOLD_W'(RST_HOLD - 1);
        cycle       <= '0;
      end

      if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);

      // The count freezes on the ending edge and saturates instead of wrapping.
      if (state == RUN && next_state == RUN && cycle != '1) cycle <= cycle + CNT_W'(1);

      if (state == RUN && next_state == DONE) finished  <= 1'b1;
      if (state == RUN && next_state == TOUT) timed_out <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
    cosim_window #(.CNT_W(CNT_W)) u_win (
      .run       (state == RUN),
      .cycle     (cycle),
      .win_start (win_start_q[i]),
      .win_end   (win_end_q[i]),
      .active    (win_active[i]),
      .open      (win_open[i])
    );
  end

endmodule
